// File: rtl/alu_issue_seq.sv
// Four-state issue sequencer: decodes RV32I ALU instructions, drives the external ALU, writes back.
// Optional macro ILLEGAL_INSN_EN adds the illegal pulse and rejects unsupported instructions.
module alu_issue_seq #(
  parameter int NREGS      = 32,
  parameter bit RESET_REGS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        insn_valid,
  output logic        insn_ready,
  input  logic [31:0] insn,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_op,
  input  logic [31:0] alu_result,
  output logic        retire_valid,
  output logic [4:0]  retire_rd,
  output logic [31:0] retire_data,
  input  logic [4:0]  dbg_raddr,
`ifdef ILLEGAL_INSN_EN
  output logic        illegal,
`endif
  output logic [31:0] dbg_rdata
);

  // state  | meaning
  // IDLE   | ready for a new instruction
  // DECODE | decode latched insn, read operands, register ALU inputs
  // EXEC   | ALU inputs stable, capture result
  // WB     | write rd, emit retire (or illegal) on the way back to IDLE
  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  logic [31:0] insn_q, insn_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [1:0]  alu_op_q, alu_op_d;
  logic [4:0]  rd_q, rd_d;
  logic        ok_q, ok_d;
  logic [31:0] result_q, result_d;
  logic        retire_valid_q, retire_valid_d;
  logic [4:0]  retire_rd_q, retire_rd_d;
  logic [31:0] retire_data_q, retire_data_d;
`ifdef ILLEGAL_INSN_EN
  logic        illegal_q, illegal_d;
`endif

  logic [31:0] regs_q [1:NREGS-1];
  logic        wr_en;

  logic [6:0]  dec_opcode;
  logic [2:0]  dec_f3;
  logic [6:0]  dec_f7;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic        dec_is_r, dec_is_i, dec_ok, dec_idx_bad;
  logic [1:0]  dec_op;
  logic [31:0] rs1_val, rs2_val, imm_val;

  assign dec_opcode = insn_q[6:0];
  assign dec_rd     = insn_q[11:7];
  assign dec_f3     = insn_q[14:12];
  assign dec_rs1    = insn_q[19:15];
  assign dec_rs2    = insn_q[24:20];
  assign dec_f7     = insn_q[31:25];
  assign dec_is_r   = (dec_opcode == 7'b0110011);
  assign dec_is_i   = (dec_opcode == 7'b0010011);
  assign imm_val    = {{20{insn_q[31]}}, insn_q[31:20]};

  always_comb begin
    dec_ok = 1'b0;
    dec_op = 2'b00;
    if (dec_is_r && dec_f7 == 7'b0000000) begin
      case (dec_f3)
        3'b000:  begin dec_ok = 1'b1; dec_op = 2'b00; end
        3'b111:  begin dec_ok = 1'b1; dec_op = 2'b10; end
        3'b110:  begin dec_ok = 1'b1; dec_op = 2'b11; end
        default: dec_ok = 1'b0;
      endcase
    end else if (dec_is_r && dec_f7 == 7'b0100000 && dec_f3 == 3'b000) begin
      dec_ok = 1'b1;
      dec_op = 2'b01;
    end else if (dec_is_i) begin
      case (dec_f3)
        3'b000:  begin dec_ok = 1'b1; dec_op = 2'b00; end
        3'b111:  begin dec_ok = 1'b1; dec_op = 2'b10; end
        3'b110:  begin dec_ok = 1'b1; dec_op = 2'b11; end
        default: dec_ok = 1'b0;
      endcase
    end
  end

  assign dec_idx_bad = ({27'd0, dec_rd} >= NREGS) || ({27'd0, dec_rs1} >= NREGS) ||
                       (dec_is_r && ({27'd0, dec_rs2} >= NREGS));

  // Index 0 and indices beyond NREGS never match, so they read as zero.
  always_comb begin
    rs1_val   = '0;
    rs2_val   = '0;
    dbg_rdata = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (dec_rs1 == 5'(i))   rs1_val   = regs_q[i];
      if (dec_rs2 == 5'(i))   rs2_val   = regs_q[i];
      if (dbg_raddr == 5'(i)) dbg_rdata = regs_q[i];
    end
  end

  always_comb begin
    state_d        = state_q;
    insn_d         = insn_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_op_d       = alu_op_q;
    rd_d           = rd_q;
    ok_d           = ok_q;
    result_d       = result_q;
    retire_valid_d = 1'b0;
    retire_rd_d    = retire_rd_q;
    retire_data_d  = retire_data_q;
    wr_en          = 1'b0;
`ifdef ILLEGAL_INSN_EN
    illegal_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (insn_valid && ready_q) begin
          insn_d  = insn;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_a_d  = rs1_val;
        alu_b_d  = dec_is_r ? rs2_val : imm_val;
        alu_op_d = dec_op;
        rd_d     = dec_rd;
`ifdef ILLEGAL_INSN_EN
        ok_d     = dec_ok && !dec_idx_bad;
        state_d  = (dec_ok && !dec_idx_bad) ? S_EXEC : S_WB;
`else
        ok_d     = dec_ok;
        state_d  = S_EXEC;
`endif
      end
      S_EXEC: begin
        result_d = alu_result;
        state_d  = S_WB;
      end
      S_WB: begin
        state_d = S_IDLE;
        if (ok_q) begin
          wr_en          = (rd_q != 5'd0);
          retire_valid_d = 1'b1;
          retire_rd_d    = rd_q;
          retire_data_d  = result_q;
        end else begin
`ifdef ILLEGAL_INSN_EN
          illegal_d      = 1'b1;
`else
          retire_valid_d = 1'b1;
          retire_rd_d    = 5'd0;
          retire_data_d  = '0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      ready_q        <= 1'b1;
      insn_q         <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= 2'b00;
      rd_q           <= '0;
      ok_q           <= 1'b0;
      result_q       <= '0;
      retire_valid_q <= 1'b0;
      retire_rd_q    <= '0;
      retire_data_q  <= '0;
`ifdef ILLEGAL_INSN_EN
      illegal_q      <= 1'b0;
`endif
      if (RESET_REGS) begin
        for (int i = 1; i < NREGS; i++) regs_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      ready_q        <= ready_d;
      insn_q         <= insn_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_op_q       <= alu_op_d;
      rd_q           <= rd_d;
      ok_q           <= ok_d;
      result_q       <= result_d;
      retire_valid_q <= retire_valid_d;
      retire_rd_q    <= retire_rd_d;
      retire_data_q  <= retire_data_d;
`ifdef ILLEGAL_INSN_EN
      illegal_q      <= illegal_d;
`endif
      for (int i = 1; i < NREGS; i++) begin
        if (wr_en && rd_q == 5'(i)) regs_q[i] <= result_q;
      end
    end
  end

  assign insn_ready   = ready_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign retire_valid = retire_valid_q;
  assign retire_rd    = retire_rd_q;
  assign retire_data  = retire_data_q;
`ifdef ILLEGAL_INSN_EN
  assign illegal      = illegal_q;
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed-vector bench for alu_issue_seq with a behavioural ALU on the result port.
module tb_alu_issue_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [1:0]  alu_op;
  logic        retire_valid;
  logic [4:0]  retire_rd;
  logic [31:0] retire_data;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
`ifdef ILLEGAL_INSN_EN
  logic        illegal;
`endif

  alu_issue_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .insn_valid   (insn_valid),
    .insn_ready   (insn_ready),
    .insn         (insn),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .retire_valid (retire_valid),
    .retire_rd    (retire_rd),
    .retire_data  (retire_data),
    .dbg_raddr    (dbg_raddr),
`ifdef ILLEGAL_INSN_EN
    .illegal      (illegal),
`endif
    .dbg_rdata    (dbg_rdata)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      2'b00:   alu_result = alu_a + alu_b;
      2'b01:   alu_result = alu_a - alu_b;
      2'b10:   alu_result = alu_a & alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] insn;
    bit          chk_alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    bit          ok;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  dreg;
    logic [31:0] dval;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];
  int n_vec = 0;
  int n_err = 0;
  int last_ret = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i, input bit chk_gap);
    vec_t v;
    int w;
    v = vecs[i];
    w = 0;
    while (!insn_ready && w < 10) begin
      tick();
      w++;
    end
    chk($sformatf("v%0d ready_wait", i), 32'(insn_ready), 32'd1);
    insn       = v.insn;
    insn_valid = 1'b1;
    tick();
    insn_valid = 1'b0;
    chk($sformatf("v%0d retire_low_hs", i), 32'(retire_valid), 32'd0);
    tick();
    chk($sformatf("v%0d ready_busy", i), 32'(insn_ready), 32'd0);
    if (v.chk_alu) begin
      chk($sformatf("v%0d alu_a", i), alu_a, v.a);
      chk($sformatf("v%0d alu_b", i), alu_b, v.b);
      chk($sformatf("v%0d alu_op", i), 32'(alu_op), 32'(v.op));
    end
    tick();
    if (v.chk_alu) chk($sformatf("v%0d alu_op_exec", i), 32'(alu_op), 32'(v.op));
`ifdef ILLEGAL_INSN_EN
    if (!v.ok) begin
      chk($sformatf("v%0d illegal_hi", i), 32'(illegal), 32'd1);
      chk($sformatf("v%0d no_retire", i), 32'(retire_valid), 32'd0);
      tick();
      chk($sformatf("v%0d illegal_lo", i), 32'(illegal), 32'd0);
      dbg_raddr = v.dreg;
      #1;
      chk($sformatf("v%0d dbg", i), dbg_rdata, v.dval);
      return;
    end
    chk($sformatf("v%0d illegal_lo", i), 32'(illegal), 32'd0);
`endif
    chk($sformatf("v%0d retire_early", i), 32'(retire_valid), 32'd0);
    tick();
    chk($sformatf("v%0d retire_valid", i), 32'(retire_valid), 32'd1);
    chk($sformatf("v%0d retire_rd", i), 32'(retire_rd), 32'(v.rd));
    chk($sformatf("v%0d retire_data", i), retire_data, v.data);
    if (chk_gap) chk($sformatf("v%0d retire_gap", i), 32'(cyc - last_ret), 32'd4);
    last_ret  = cyc;
    dbg_raddr = v.dreg;
    #1;
    chk($sformatf("v%0d dbg x%0d", i, v.dreg), dbg_rdata, v.dval);
  endtask

  initial begin
    //         insn          alu a         b             op    ok  rd     data          dreg   dval
    vecs[0]  = '{32'h00500093, 1, 32'h0,        32'h5,        2'b00, 1, 5'd1,  32'h5,        5'd1,  32'h5};
    vecs[1]  = '{32'hFFD00113, 1, 32'h0,        32'hFFFFFFFD, 2'b00, 1, 5'd2,  32'hFFFFFFFD, 5'd2,  32'hFFFFFFFD};
    vecs[2]  = '{32'h402081B3, 1, 32'h5,        32'hFFFFFFFD, 2'b01, 1, 5'd3,  32'h8,        5'd3,  32'h8};
    vecs[3]  = '{32'h00210233, 1, 32'hFFFFFFFD, 32'hFFFFFFFD, 2'b00, 1, 5'd4,  32'hFFFFFFFA, 5'd4,  32'hFFFFFFFA};
    vecs[4]  = '{32'h0F006293, 1, 32'h0,        32'hF0,       2'b11, 1, 5'd5,  32'hF0,       5'd5,  32'hF0};
    vecs[5]  = '{32'h0302F313, 1, 32'hF0,       32'h30,       2'b10, 1, 5'd6,  32'h30,       5'd6,  32'h30};
    vecs[6]  = '{32'h00700013, 1, 32'h0,        32'h7,        2'b00, 1, 5'd0,  32'h7,        5'd0,  32'h0};
    vecs[7]  = '{32'h0030E433, 1, 32'h5,        32'h8,        2'b11, 1, 5'd8,  32'hD,        5'd8,  32'hD};
    vecs[8]  = '{32'h005374B3, 1, 32'h30,       32'hF0,       2'b10, 1, 5'd9,  32'h30,       5'd9,  32'h30};
    vecs[9]  = '{32'hFFF00513, 1, 32'h0,        32'hFFFFFFFF, 2'b00, 1, 5'd10, 32'hFFFFFFFF, 5'd10, 32'hFFFFFFFF};
    vecs[10] = '{32'h00150593, 1, 32'hFFFFFFFF, 32'h1,        2'b00, 1, 5'd11, 32'h0,        5'd11, 32'h0};
    vecs[11] = '{32'hFF057613, 1, 32'hFFFFFFFF, 32'hFFFFFFF0, 2'b10, 1, 5'd12, 32'hFFFFFFF0, 5'd12, 32'hFFFFFFF0};
    vecs[12] = '{32'h00001033, 0, 32'h0,        32'h0,        2'b00, 0, 5'd0,  32'h0,        5'd0,  32'h0};
    vecs[13] = '{32'h001096B3, 0, 32'h0,        32'h0,        2'b00, 0, 5'd0,  32'h0,        5'd13, 32'h0};

    rst_n      = 1'b0;
    insn_valid = 1'b0;
    insn       = '0;
    dbg_raddr  = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst insn_ready", 32'(insn_ready), 32'd1);
    chk("rst alu_a", alu_a, 32'h0);
    chk("rst alu_b", alu_b, 32'h0);
    chk("rst alu_op", 32'(alu_op), 32'd0);
    chk("rst retire_valid", 32'(retire_valid), 32'd0);
    chk("rst retire_rd", 32'(retire_rd), 32'd0);
    chk("rst retire_data", retire_data, 32'h0);
`ifdef ILLEGAL_INSN_EN
    chk("rst illegal", 32'(illegal), 32'd0);
`endif
    for (int r = 0; r < 32; r++) begin
      dbg_raddr = 5'(r);
      #1;
      chk($sformatf("rst dbg x%0d", r), dbg_rdata, 32'h0);
    end

    for (int i = 0; i < NV; i++) run_vec(i, i > 0);

    // Reset while ADDI x7,x0,9 sits in EXEC: it must vanish without a trace.
    tick();
    insn       = 32'h00900393;
    insn_valid = 1'b1;
    tick();
    insn_valid = 1'b0;
    tick();
    chk("abort alu_b", alu_b, 32'h9);
    rst_n = 1'b0;
    tick();
    chk("abort retire", 32'(retire_valid), 32'd0);
    chk("abort ready", 32'(insn_ready), 32'd1);
    chk("abort alu_b_rst", alu_b, 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("abort no_retire %0d", k), 32'(retire_valid), 32'd0);
    end
    dbg_raddr = 5'd7;
    #1;
    chk("abort dbg x7", dbg_rdata, 32'h0);
    dbg_raddr = 5'd1;
    #1;
    chk("abort dbg x1 cleared", dbg_rdata, 32'h0);
    run_vec(0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
